// File: rtl/axi_wr_tlp_rx.sv
// AXI4 write responder for MCTP-over-PCIe VDM bursts: checks the TLP header on beat 0,
// streams payload beats downstream and answers with OKAY/SLVERR.
module axi_wr_tlp_rx #(
    parameter logic [15:0] VENDOR_ID = 16'h1AB4,
    parameter logic [7:0]  MSG_CODE  = 8'h7F,
    parameter logic [3:0]  HDR_VER   = 4'h1
) (
    input  logic         i_clk,
    input  logic         i_reset_n,

    input  logic [6:0]   I_AWID,
    input  logic [63:0]  I_AWADDR,
    input  logic [7:0]   I_AWLEN,
    input  logic [2:0]   I_AWSIZE,
    input  logic [1:0]   I_AWBURST,
    input  logic [63:0]  I_AWUSER,
    input  logic         I_AWLOCK,
    input  logic [3:0]   I_AWCACHE,
    input  logic [2:0]   I_AWPROT,
    input  logic         I_AWVALID,
    output logic         O_AWREADY,

    input  logic [255:0] I_WDATA,
    input  logic [31:0]  I_WSTRB,
    input  logic         I_WLAST,
    input  logic [15:0]  I_WUSER,
    input  logic         I_WVALID,
    output logic         O_WREADY,

    output logic [6:0]   O_BID,
    output logic [1:0]   O_BRESP,
    output logic         O_BVALID,
    input  logic         I_BREADY,

    output logic [127:0] O_HDR,
    output logic         O_HDR_VALID,
    output logic         O_HDR_ERR,

    output logic [255:0] O_PLD_DATA,
    output logic [31:0]  O_PLD_STRB,
    output logic         O_PLD_LAST,
    output logic         O_PLD_VALID,
    input  logic         I_PLD_READY,

    output logic [7:0]   O_ERR_CNT
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    logic         aw_ready_q;
    logic [7:0]   aw_len_q;
    logic [7:0]   beat_cnt;
    logic         attr_err;
    logic         wlast_err;
    logic         hdr_err_flag;
    logic [6:0]   bid_q;
    logic [1:0]   bresp_q;
    logic         bvalid_q;
    logic [127:0] hdr_q;
    logic         hdr_valid_q;
    logic         hdr_err_q;
    logic [7:0]   err_cnt_q;

    logic in_data;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic first_beat;
    logic cnt_at_len;
    logic terminal;
    logic beat_wlast_err;
    logic hdr_fail;
    logic unused_inputs;

    function automatic logic hdr_check_fail(input logic [127:0] h);
        return (h[7:5] != 3'b011) ||
               (h[4:3] != 2'b10) ||
               (h[63:56] != MSG_CODE) ||
               ({h[87:80], h[95:88]} != VENDOR_ID) ||
               (h[99:96] != HDR_VER);
    endfunction

    assign in_data        = (state == DATA);
    assign aw_hs          = aw_ready_q && I_AWVALID;
    assign w_hs           = in_data && I_WVALID && I_PLD_READY;
    assign b_hs           = bvalid_q && I_BREADY;
    assign first_beat     = (beat_cnt == 8'd0);
    assign cnt_at_len     = (beat_cnt == aw_len_q);
    assign terminal       = I_WLAST || cnt_at_len;
    // Either an early WLAST or a missing one at the AWLEN beat is a protocol error
    assign beat_wlast_err = (I_WLAST != cnt_at_len);
    assign hdr_fail       = hdr_check_fail(I_WDATA[127:0]);

    assign unused_inputs = ^{I_AWADDR, I_AWUSER, I_AWLOCK, I_AWCACHE, I_AWPROT, I_WUSER};

    // W channel is a zero-latency pass-through; ready never looks at WVALID
    assign O_WREADY    = in_data && I_PLD_READY;
    assign O_PLD_VALID = in_data && I_WVALID;
    assign O_PLD_DATA  = in_data ? I_WDATA : 256'd0;
    assign O_PLD_STRB  = !in_data  ? 32'd0 :
                         first_beat ? {I_WSTRB[31:16], 16'h0000} : I_WSTRB;
    assign O_PLD_LAST  = in_data && I_WVALID && terminal;

    assign O_AWREADY   = aw_ready_q;
    assign O_BID       = bid_q;
    assign O_BRESP     = bresp_q;
    assign O_BVALID    = bvalid_q;
    assign O_HDR       = hdr_q;
    assign O_HDR_VALID = hdr_valid_q;
    assign O_HDR_ERR   = hdr_err_q;
    assign O_ERR_CNT   = err_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            aw_ready_q   <= 1'b0;
            aw_len_q     <= 8'd0;
            beat_cnt     <= 8'd0;
            attr_err     <= 1'b0;
            wlast_err    <= 1'b0;
            hdr_err_flag <= 1'b0;
            bid_q        <= 7'd0;
            bresp_q      <= RESP_OKAY;
            bvalid_q     <= 1'b0;
            hdr_q        <= 128'd0;
            hdr_valid_q  <= 1'b0;
            hdr_err_q    <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            hdr_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    aw_ready_q <= 1'b1;
                    if (aw_hs) begin
                        aw_ready_q <= 1'b0;
                        bid_q      <= I_AWID;
                        aw_len_q   <= I_AWLEN;
                        attr_err   <= (I_AWSIZE != 3'd5) || (I_AWBURST != 2'b01);
                        beat_cnt   <= 8'd0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (first_beat) begin
                            hdr_q        <= I_WDATA[127:0];
                            hdr_valid_q  <= 1'b1;
                            hdr_err_q    <= hdr_fail;
                            hdr_err_flag <= hdr_fail;
                        end
                        // The current beat's header/WLAST verdicts are folded in directly
                        // because their flags only land on this same edge
                        if (terminal) begin
                            wlast_err <= beat_wlast_err;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (attr_err || wlast_err || beat_wlast_err ||
                                          hdr_err_flag || (first_beat && hdr_fail))
                                         ? RESP_SLVERR : RESP_OKAY;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        if ((bresp_q == RESP_SLVERR) && (err_cnt_q != 8'hFF))
                            err_cnt_q <= err_cnt_q + 8'd1;
                        bvalid_q     <= 1'b0;
                        bresp_q      <= RESP_OKAY;
                        attr_err     <= 1'b0;
                        wlast_err    <= 1'b0;
                        hdr_err_flag <= 1'b0;
                        aw_ready_q   <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    aw_ready_q <= 1'b0;
                    bvalid_q   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_tlp_rx.sv
// Scoreboard bench for axi_wr_tlp_rx: payload, header and B responses are predicted
// when stimulus is driven and popped when the DUT presents them.
module tb_axi_wr_tlp_rx;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic [6:0]   I_AWID;
    logic [63:0]  I_AWADDR;
    logic [7:0]   I_AWLEN;
    logic [2:0]   I_AWSIZE;
    logic [1:0]   I_AWBURST;
    logic [63:0]  I_AWUSER;
    logic         I_AWLOCK;
    logic [3:0]   I_AWCACHE;
    logic [2:0]   I_AWPROT;
    logic         I_AWVALID;
    logic         O_AWREADY;
    logic [255:0] I_WDATA;
    logic [31:0]  I_WSTRB;
    logic         I_WLAST;
    logic [15:0]  I_WUSER;
    logic         I_WVALID;
    logic         O_WREADY;
    logic [6:0]   O_BID;
    logic [1:0]   O_BRESP;
    logic         O_BVALID;
    logic         I_BREADY;
    logic [127:0] O_HDR;
    logic         O_HDR_VALID;
    logic         O_HDR_ERR;
    logic [255:0] O_PLD_DATA;
    logic [31:0]  O_PLD_STRB;
    logic         O_PLD_LAST;
    logic         O_PLD_VALID;
    logic         I_PLD_READY;
    logic [7:0]   O_ERR_CNT;

    localparam logic [127:0] HDR_GOOD = 128'h00000001_B41A0000_7F000000_20000073;
    localparam logic [127:0] HDR_BADV = 128'h00000001_B41B0000_7F000000_20000073;

    typedef struct packed { logic [255:0] data; logic [31:0] strb; logic last; } pld_t;
    typedef struct packed { logic [127:0] hdr; logic err; } hdr_t;
    typedef struct packed { logic [6:0] id; logic [1:0] resp; } b_t;

    pld_t pld_q[$];
    hdr_t hdr_q[$];
    b_t   b_q[$];
    pld_t pe;
    hdr_t he;
    b_t   be;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_err_cnt = 8'd0;

    axi_wr_tlp_rx dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .I_AWID(I_AWID), .I_AWADDR(I_AWADDR), .I_AWLEN(I_AWLEN), .I_AWSIZE(I_AWSIZE),
        .I_AWBURST(I_AWBURST), .I_AWUSER(I_AWUSER), .I_AWLOCK(I_AWLOCK),
        .I_AWCACHE(I_AWCACHE), .I_AWPROT(I_AWPROT), .I_AWVALID(I_AWVALID),
        .O_AWREADY(O_AWREADY),
        .I_WDATA(I_WDATA), .I_WSTRB(I_WSTRB), .I_WLAST(I_WLAST), .I_WUSER(I_WUSER),
        .I_WVALID(I_WVALID), .O_WREADY(O_WREADY),
        .O_BID(O_BID), .O_BRESP(O_BRESP), .O_BVALID(O_BVALID), .I_BREADY(I_BREADY),
        .O_HDR(O_HDR), .O_HDR_VALID(O_HDR_VALID), .O_HDR_ERR(O_HDR_ERR),
        .O_PLD_DATA(O_PLD_DATA), .O_PLD_STRB(O_PLD_STRB), .O_PLD_LAST(O_PLD_LAST),
        .O_PLD_VALID(O_PLD_VALID), .I_PLD_READY(I_PLD_READY),
        .O_ERR_CNT(O_ERR_CNT)
    );

    always #5 i_clk = ~i_clk;

    // Scoreboard side: every DUT output event must match the oldest prediction
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (O_PLD_VALID && O_WREADY) begin
                vectors++;
                if (pld_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL pld_unexpected: beat data=%h with nothing queued", O_PLD_DATA);
                end else begin
                    pe = pld_q.pop_front();
                    if (O_PLD_DATA !== pe.data || O_PLD_STRB !== pe.strb || O_PLD_LAST !== pe.last) begin
                        miscompares++;
                        $display("[TB] FAIL pld_beat: got data=%h strb=%h last=%b, want data=%h strb=%h last=%b",
                                 O_PLD_DATA, O_PLD_STRB, O_PLD_LAST, pe.data, pe.strb, pe.last);
                    end
                end
            end
            if (O_HDR_VALID) begin
                vectors++;
                if (hdr_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL hdr_unexpected: pulse with hdr=%h", O_HDR);
                end else begin
                    he = hdr_q.pop_front();
                    if (O_HDR !== he.hdr || O_HDR_ERR !== he.err) begin
                        miscompares++;
                        $display("[TB] FAIL hdr: got hdr=%h err=%b, want hdr=%h err=%b",
                                 O_HDR, O_HDR_ERR, he.hdr, he.err);
                    end
                end
            end
            if (O_BVALID && I_BREADY) begin
                vectors++;
                if (b_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL b_unexpected: bid=%h bresp=%b", O_BID, O_BRESP);
                end else begin
                    be = b_q.pop_front();
                    if (O_BID !== be.id || O_BRESP !== be.resp) begin
                        miscompares++;
                        $display("[TB] FAIL bresp: got bid=%h bresp=%b, want bid=%h bresp=%b",
                                 O_BID, O_BRESP, be.id, be.resp);
                    end
                end
            end
        end
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drives one burst; abort_beat >= 0 asserts reset while that beat is offered
    task automatic run_burst(input logic [6:0] id, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [127:0] hdr, input int wlast_beat,
                             input int pld_stall, input int b_stall, input logic hdr_bad,
                             input logic [1:0] exp_resp, input int abort_beat);
        int nbeats;
        int t;
        logic [255:0] d;
        logic [31:0] s;
        nbeats = (wlast_beat < int'(len)) ? wlast_beat + 1 : int'(len) + 1;

        @(posedge i_clk); #1;
        I_AWID = id; I_AWLEN = len; I_AWSIZE = size; I_AWBURST = burst;
        I_AWADDR = {$urandom, $urandom}; I_AWUSER = {$urandom, $urandom};
        I_AWLOCK = 1'($urandom); I_AWCACHE = 4'($urandom); I_AWPROT = 3'($urandom);
        I_AWVALID = 1'b1;
        t = 0;
        @(negedge i_clk);
        while (!O_AWREADY && t < 50) begin @(negedge i_clk); t++; end
        if (!O_AWREADY) begin
            vectors++; miscompares++;
            $display("[TB] FAIL aw_timeout: awready=%b, want 1", O_AWREADY);
        end
        @(posedge i_clk); #1;
        I_AWVALID = 1'b0;

        for (int i = 0; i < nbeats; i++) begin
            d = rand256();
            if (i == 0) d[127:0] = hdr;
            s = $urandom;
            I_WDATA = d; I_WSTRB = s; I_WLAST = (i == wlast_beat); I_WUSER = 16'($urandom);
            I_WVALID = 1'b1;
            if (i == abort_beat) begin
                #2 i_reset_n = 1'b0;
                I_WVALID = 1'b0; I_WLAST = 1'b0;
                return;
            end
            pld_q.push_back('{d, (i == 0) ? {s[31:16], 16'h0000} : s, (i == nbeats - 1)});
            if (i == 0) hdr_q.push_back('{hdr, hdr_bad});
            I_PLD_READY = (pld_stall == 0);
            @(negedge i_clk);
            if (i == 0) begin
                vectors++;
                if (O_AWREADY !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL awready_in_data: got %b, want 0", O_AWREADY);
                end
            end
            for (int k = 0; k < pld_stall; k++) begin
                vectors++;
                if (O_WREADY !== 1'b0 || O_PLD_VALID !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL wready_stall: got wready=%b pld_valid=%b, want 0/1", O_WREADY, O_PLD_VALID);
                end
                @(posedge i_clk); #1;
                if (k == pld_stall - 1) I_PLD_READY = 1'b1;
                @(negedge i_clk);
            end
            t = 0;
            while (!O_WREADY && t < 20) begin @(negedge i_clk); t++; end
            vectors++;
            if (O_WREADY !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL wready_track: got %b, want 1 with pld_ready high", O_WREADY);
            end
            @(posedge i_clk); #1;
        end
        I_WVALID = 1'b0; I_WLAST = 1'b0;
        b_q.push_back('{id, exp_resp});
        if (exp_resp == 2'b10 && exp_err_cnt != 8'hFF) exp_err_cnt++;

        @(negedge i_clk);
        for (int k = 0; k <= b_stall; k++) begin
            vectors++;
            if (O_BVALID !== 1'b1 || O_BID !== id || O_BRESP !== exp_resp) begin
                miscompares++;
                $display("[TB] FAIL b_hold: got bvalid=%b bid=%h bresp=%b, want 1/%h/%b",
                         O_BVALID, O_BID, O_BRESP, id, exp_resp);
            end
            if (k < b_stall) begin @(posedge i_clk); #1; @(negedge i_clk); end
        end
        @(posedge i_clk); #1;
        I_BREADY = 1'b1;
        @(posedge i_clk); #1;
        I_BREADY = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (O_AWREADY !== 1'b1 || O_BVALID !== 1'b0 || O_ERR_CNT !== exp_err_cnt) begin
            miscompares++;
            $display("[TB] FAIL after_b: got awready=%b bvalid=%b err_cnt=%0d, want 1/0/%0d",
                     O_AWREADY, O_BVALID, O_ERR_CNT, exp_err_cnt);
        end
        vectors++;
        if (pld_q.size() != 0 || hdr_q.size() != 0 || b_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: left pld=%0d hdr=%0d b=%0d, want 0/0/0",
                     pld_q.size(), hdr_q.size(), b_q.size());
            pld_q.delete(); hdr_q.delete(); b_q.delete();
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        I_AWID = '0; I_AWADDR = '0; I_AWLEN = '0; I_AWSIZE = '0; I_AWBURST = '0; I_AWUSER = '0;
        I_AWLOCK = 1'b0; I_AWCACHE = '0; I_AWPROT = '0; I_AWVALID = 1'b0;
        I_WDATA = '0; I_WSTRB = '0; I_WLAST = 1'b0; I_WUSER = '0; I_WVALID = 1'b0;
        I_BREADY = 1'b0; I_PLD_READY = 1'b1;
        repeat (3) @(negedge i_clk);
        vectors++;
        if ({O_AWREADY, O_WREADY, O_BVALID, O_BRESP, O_BID, O_HDR, O_HDR_VALID, O_HDR_ERR,
             O_PLD_VALID, O_PLD_LAST, O_PLD_DATA, O_PLD_STRB, O_ERR_CNT} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: awready=%b bvalid=%b err_cnt=%0d hdr=%h, want all zero",
                     O_AWREADY, O_BVALID, O_ERR_CNT, O_HDR);
        end
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        vectors++;
        if (O_AWREADY !== 1'b1 || O_WREADY !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got awready=%b wready=%b, want 1/0", O_AWREADY, O_WREADY);
        end
    endtask

    task automatic test_nominal();
        run_burst(7'h15, 8'd4, 3'd5, 2'b01, HDR_GOOD, 4, 0, 0, 1'b0, 2'b00, -1);
    endtask

    task automatic test_bad_vendor();
        run_burst(7'h22, 8'd4, 3'd5, 2'b01, HDR_BADV, 4, 0, 0, 1'b1, 2'b10, -1);
    endtask

    task automatic test_wlast_errors();
        run_burst(7'h31, 8'd3, 3'd5, 2'b01, HDR_GOOD, 1, 0, 0, 1'b0, 2'b10, -1);
        run_burst(7'h32, 8'd3, 3'd5, 2'b01, HDR_GOOD, 99, 0, 0, 1'b0, 2'b10, -1);
    endtask

    task automatic test_attr_error();
        run_burst(7'h41, 8'd2, 3'd4, 2'b01, HDR_GOOD, 2, 0, 0, 1'b0, 2'b10, -1);
        run_burst(7'h42, 8'd2, 3'd5, 2'b00, HDR_GOOD, 2, 0, 0, 1'b0, 2'b10, -1);
    endtask

    task automatic test_single_beat();
        run_burst(7'h05, 8'd0, 3'd5, 2'b01, HDR_GOOD, 0, 0, 0, 1'b0, 2'b00, -1);
        run_burst(7'h06, 8'd0, 3'd5, 2'b01, HDR_BADV, 0, 0, 0, 1'b1, 2'b10, -1);
    endtask

    task automatic test_backpressure();
        run_burst(7'h7A, 8'd4, 3'd5, 2'b01, HDR_GOOD, 4, 3, 5, 1'b0, 2'b00, -1);
    endtask

    task automatic test_reset_mid_burst();
        run_burst(7'h11, 8'd4, 3'd5, 2'b01, HDR_GOOD, 4, 0, 0, 1'b0, 2'b00, 2);
        pld_q.delete(); hdr_q.delete(); b_q.delete();
        exp_err_cnt = 8'd0;
        @(negedge i_clk);
        vectors++;
        if ({O_AWREADY, O_WREADY, O_BVALID, O_BRESP, O_BID, O_HDR, O_HDR_VALID, O_HDR_ERR,
             O_PLD_VALID, O_PLD_LAST, O_PLD_DATA, O_PLD_STRB, O_ERR_CNT} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_values: awready=%b bvalid=%b err_cnt=%0d hdr=%h, want all zero",
                     O_AWREADY, O_BVALID, O_ERR_CNT, O_HDR);
        end
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            vectors++;
            if (O_BVALID !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_no_b: got bvalid=%b, want 0", O_BVALID);
            end
        end
        run_burst(7'h15, 8'd4, 3'd5, 2'b01, HDR_GOOD, 4, 0, 0, 1'b0, 2'b00, -1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_vendor();
        test_wlast_errors();
        test_attr_error();
        test_single_beat();
        test_backpressure();
        test_reset_mid_burst();
        repeat (2) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
